// File: rtl/uart_case_bridge.sv
// UART receiver -> case translation -> byte FIFO -> UART transmitter, one clock domain.
// Adds transmit pause, FIFO occupancy output and sticky framing/overflow flags.
module uart_case_bridge #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 9600,
    parameter int DEPTH     = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic [1:0]    mode,
    input  logic          tx_pause,
    input  logic          clr_err,
    output logic          tx,
    output logic [AW:0]   fifo_count,
    output logic          frame_err,
    output logic          overflow
);

    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic          rx_meta, rxs;
    rx_state_t     rstate;
    logic [CW-1:0] rcnt;
    logic [2:0]    rbit;
    logic [7:0]    rshift;

    tx_state_t     tstate;
    logic [CW-1:0] tcnt;
    logic [2:0]    tbit;
    logic [7:0]    tshift;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    logic          stop_tick, push, frame_set, full, pop, do_push, ovf_set, tx_end;
    logic [7:0]    push_data;

    function automatic logic [7:0] translate(input logic [7:0] b, input logic [1:0] m);
        logic [7:0] r;
        r = b;
        if (m[0] && b >= 8'h61 && b <= 8'h7A)
            r = b - 8'h20;
        else if (m[1] && b >= 8'h41 && b <= 8'h5A)
            r = b + 8'h20;
        return r;
    endfunction

    // Push and pop are decided combinationally so the FIFO updates on the stop-sample edge
    // and a back-to-back frame can start on the edge that ends the previous stop bit.
    always_comb begin
        stop_tick = (rstate == R_STOP) && (rcnt == CNT_LAST);
        push      = stop_tick && rxs;
        frame_set = stop_tick && !rxs;
        push_data = translate(rshift, mode);
        full      = (fifo_count == FULL);
        tx_end    = (tstate == T_STOP) && (tcnt == CNT_LAST);
        pop       = ((tstate == T_IDLE) || tx_end) && (fifo_count != '0) && !tx_pause;
        do_push   = push && (!full || pop);
        ovf_set   = push && full && !pop;
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receiver FSM: mid-bit sampling, glitch rejection and break lockout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rcnt   <= '0;
            rbit   <= '0;
            rshift <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (!rxs) begin
                        rstate <= R_START;
                        rcnt   <= '0;
                        rbit   <= '0;
                    end
                end
                R_START: begin
                    if (rcnt == CNT_HALF) begin
                        rcnt   <= '0;
                        rstate <= rxs ? R_IDLE : R_DATA;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rcnt == CNT_LAST) begin
                        rcnt   <= '0;
                        rshift <= {rxs, rshift[7:1]};
                        rbit   <= rbit + 3'd1;
                        if (rbit == 3'd7)
                            rstate <= R_STOP;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (rcnt == CNT_LAST) begin
                        rcnt   <= '0;
                        rstate <= rxs ? R_IDLE : R_WAIT;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                R_WAIT: begin
                    if (rxs)
                        rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // FIFO storage; contents are not reset, only the pointers
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmitter FSM with registered line output; pause only gates new starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate <= T_IDLE;
            tcnt   <= '0;
            tbit   <= '0;
            tshift <= '0;
            tx     <= 1'b1;
        end else if (pop) begin
            tshift <= mem[rptr];
            tx     <= 1'b0;
            tstate <= T_START;
            tcnt   <= '0;
            tbit   <= '0;
        end else begin
            case (tstate)
                T_IDLE: tx <= 1'b1;
                T_START: begin
                    if (tcnt == CNT_LAST) begin
                        tcnt   <= '0;
                        tx     <= tshift[0];
                        tstate <= T_DATA;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                T_DATA: begin
                    if (tcnt == CNT_LAST) begin
                        tcnt <= '0;
                        if (tbit == 3'd7) begin
                            tx     <= 1'b1;
                            tstate <= T_STOP;
                        end else begin
                            tbit   <= tbit + 3'd1;
                            tx     <= tshift[1];
                            tshift <= {1'b0, tshift[7:1]};
                        end
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                T_STOP: begin
                    if (tcnt == CNT_LAST) begin
                        tcnt   <= '0;
                        tstate <= T_IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: tstate <= T_IDLE;
            endcase
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= frame_set | (frame_err & ~clr_err);
            overflow  <= ovf_set | (overflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_case_bridge.sv
// Directed bench for uart_case_bridge at 10 clocks/bit, 4-entry FIFO.
module tb_uart_case_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [1:0] mode;
    logic       tx_pause;
    logic       clr_err;
    logic       tx;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] q_byte[$];
    int         q_start[$];
    logic       q_stop[$];

    uart_case_bridge #(
        .CLK_FREQ(1000000),
        .BAUD_RATE(100000),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .mode(mode),
        .tx_pause(tx_pause),
        .clr_err(clr_err),
        .tx(tx),
        .fifo_count(fifo_count),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decode tx frames sampled at mid-bit on falling clock edges
    initial begin
        logic [7:0] b;
        logic       sb;
        int         t0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = tx;
                end
                repeat (10) @(negedge clk);
                sb = tx;
                q_byte.push_back(b);
                q_start.push_back(t0);
                q_stop.push_back(sb);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, observed no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one serial frame; starts and ends on a falling clock edge
    task automatic send_byte(input logic [7:0] b, input logic stop, input int sw_bit,
                             input logic [1:0] sw_mode);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == sw_bit) mode = sw_mode;
            repeat (10) @(negedge clk);
        end
        rx = stop;
        repeat (10) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (q_byte.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_bytes", q_byte.size(), n);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (q_byte.size() > 0) begin
            got = q_byte.pop_front();
            check({tag, "_stop"}, q_stop.pop_front(), 1'b1);
            void'(q_start.pop_front());
        end
        check(tag, got, exp);
    endtask

    initial begin
        int s0, s1, s2, k;

        rst_n = 1'b0; rx = 1'b1; mode = 2'b00; tx_pause = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // To-upper, contiguous frames
        mode = 2'b01;
        send_byte(8'h61, 1'b1, -1, 2'b00);
        send_byte(8'h7A, 1'b1, -1, 2'b00);
        send_byte(8'h35, 1'b1, -1, 2'b00);
        wait_bytes(3, 400);
        s0 = q_start.size() > 0 ? q_start[0] : 0;
        s1 = q_start.size() > 1 ? q_start[1] : 0;
        s2 = q_start.size() > 2 ? q_start[2] : 0;
        check("gap_0_1", s1 - s0, 100);
        check("gap_1_2", s2 - s1, 100);
        expect_byte("upper_a", 8'h41);
        expect_byte("upper_z", 8'h5A);
        expect_byte("upper_5", 8'h35);
        check("upper_frame_err", frame_err, 1'b0);
        check("upper_overflow", overflow, 1'b0);
        repeat (60) @(negedge clk);

        // Swap case, pass-through, and mode change in the middle of a frame
        mode = 2'b11;
        send_byte(8'h47, 1'b1, -1, 2'b00);
        send_byte(8'h6D, 1'b1, -1, 2'b00);
        send_byte(8'h40, 1'b1, -1, 2'b00);
        mode = 2'b00;
        send_byte(8'h61, 1'b1, -1, 2'b00);
        send_byte(8'h62, 1'b1, 4, 2'b01);
        wait_bytes(5, 300);
        expect_byte("swap_G", 8'h67);
        expect_byte("swap_m", 8'h4D);
        expect_byte("swap_at", 8'h40);
        expect_byte("pass_a", 8'h61);
        expect_byte("midframe_mode", 8'h42);
        repeat (60) @(negedge clk);

        // Framing error followed by a held break
        mode = 2'b00;
        send_byte(8'h55, 1'b0, -1, 2'b00);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_set", frame_err, 1'b1);
        check("ferr_count", fifo_count, 3'd0);
        check("ferr_no_tx", q_byte.size(), 0);
        check("ferr_overflow", overflow, 1'b0);
        send_byte(8'h41, 1'b1, -1, 2'b00);
        wait_bytes(1, 200);
        expect_byte("after_break", 8'h41);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ferr_clear", frame_err, 1'b0);
        repeat (60) @(negedge clk);

        // Pause with overflow, then drain in order
        tx_pause = 1'b1;
        for (int i = 0; i < 6; i++)
            send_byte(8'h30 + 8'(i), 1'b1, -1, 2'b00);
        repeat (5) @(negedge clk);
        check("pause_count", fifo_count, 3'd4);
        check("pause_overflow", overflow, 1'b1);
        check("pause_tx_idle", tx, 1'b1);
        check("pause_no_tx", q_byte.size(), 0);
        tx_pause = 1'b0;
        wait_bytes(4, 600);
        expect_byte("drain_0", 8'h30);
        expect_byte("drain_1", 8'h31);
        expect_byte("drain_2", 8'h32);
        expect_byte("drain_3", 8'h33);
        repeat (60) @(negedge clk);
        check("drain_count", fifo_count, 3'd0);
        check("drain_no_extra", q_byte.size(), 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovf_clear", overflow, 1'b0);

        // Short glitch while idle
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        check("glitch_count", fifo_count, 3'd0);
        check("glitch_frame_err", frame_err, 1'b0);
        check("glitch_no_tx", q_byte.size(), 0);
        check("glitch_tx", tx, 1'b1);

        // Reset in the middle of a transmitted frame
        tx_pause = 1'b1;
        send_byte(8'h4B, 1'b1, -1, 2'b00);
        send_byte(8'h4C, 1'b1, -1, 2'b00);
        repeat (5) @(negedge clk);
        check("pre_rst_count", fifo_count, 3'd2);
        tx_pause = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_tx_start", tx, 1'b0);
        repeat (30) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_count", fifo_count, 3'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        q_byte.delete();
        q_start.delete();
        q_stop.delete();
        check("post_rst_count", fifo_count, 3'd0);
        mode = 2'b01;
        send_byte(8'h6B, 1'b1, -1, 2'b00);
        wait_bytes(1, 200);
        expect_byte("post_rst_byte", 8'h4B);
        repeat (60) @(negedge clk);
        check("post_rst_no_extra", q_byte.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_case_bridge.md
# uart_case_bridge

Parametrised successor to the single-rate UART upper-case converter. It contains a UART receiver, a runtime-selectable case-translation stage, a power-of-two byte FIFO and a UART transmitter, all in one clock domain. Bit rate, FIFO depth and translation mode are configurable. It adds transmit pause (flow control), a FIFO occupancy output and sticky framing and overflow flags. It sits directly behind the chip pins, and is the top-level datapath of the converter tile.

## Interface
Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); must be >= 8.
- DEPTH, 16, FIFO entries; power of two, >= 2. AW = $clog2(DEPTH).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high; asynchronous, 2-flop synchronised internally.
- mode  in  2  translation: 00 pass, 01 to-upper, 10 to-lower, 11 swap case.
- tx_pause  in  1  high = transmitter starts no new frame.
- clr_err  in  1  one-cycle pulse clears frame_err and overflow.
- tx  out  1  serial output, idle high.
- fifo_count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- frame_err  out  1  sticky: a byte with a low stop bit was received.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.

## Operation
Reset values:
- tx = 1, fifo_count = 0, frame_err = 0, overflow = 0.
- RX FSM in R_IDLE, TX FSM in T_IDLE, FIFO pointers 0.

RX FSM, working on the synchronised rx (rxs):
- R_IDLE: rxs = 0 -> R_START, bit counter cleared.
- R_START: wait CLKS_PER_BIT/2 cycles, then sample. rxs = 0 -> R_DATA; rxs = 1 (glitch) -> R_IDLE, no flags set.
- R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into the shift register. Then -> R_STOP.
- R_STOP: sample after CLKS_PER_BIT cycles.
  - rxs = 1: byte accepted, push request for exactly that cycle, -> R_IDLE.
  - rxs = 0: frame_err set, byte discarded, -> R_WAIT.
- R_WAIT: stay until rxs = 1, then -> R_IDLE. This prevents a break from re-triggering the receiver.

Translation (combinational on the accepted byte; mode is sampled in the push cycle):
- Lower-case letter = 0x61..0x7A; upper-case letter = 0x41..0x5A.
- To-upper subtracts 0x20 from lower-case letters only.
- To-lower adds 0x20 to upper-case letters only.
- Swap does both. Non-letters always pass unchanged.

FIFO:
- Circular buffer with AW-bit pointers that wrap at DEPTH. Occupancy counter is AW+1 bits.
- Push when count < DEPTH, or when a pop happens in the same cycle.
- Push when count = DEPTH with no pop: byte dropped, overflow set.
- Simultaneous push and pop: both succeed, count unchanged; this holds at full and at any non-empty level.
- Pop only when count > 0. A byte pushed into an empty FIFO cannot be popped in the same cycle.

TX FSM:
- T_IDLE: count > 0 and tx_pause = 0 -> pop the head into the shift register, tx = 0, -> T_START.
- T_START, T_DATA (8 bits, LSB first), T_STOP (tx = 1): each bit lasts exactly CLKS_PER_BIT cycles. After T_STOP -> T_IDLE.
- tx_pause never truncates a frame in progress. It only blocks the next start.

Error flags:
- Sticky until clr_err. A set event in the same cycle as clr_err wins (flag stays 1).

## Timing
- rx falling edge to entering R_START: 2 cycles (synchroniser) + 1 cycle.
- Stop-bit sample cycle = push edge E0. fifo_count updates at E0.
- If TX is idle and unpaused, tx falls at E0+1. The FIFO holds the byte for at least 1 cycle.
- Back-to-back TX frames: the next start bit immediately follows the full stop bit. Frame length is exactly 10*CLKS_PER_BIT cycles.
- Reset asserted mid-frame: tx = 1 asynchronously, FIFO contents are lost, and the receiver needs a fresh start edge after release.

## Test plan
Use CLK_FREQ = 1000000, BAUD_RATE = 100000 (10 clocks/bit) and DEPTH = 4 unless noted.
- mode = 01, send 0x61 'a', 0x7A 'z', 0x35 '5' -> tx emits 0x41, 0x5A, 0x35. Each frame is 100 cycles with no gaps. frame_err = 0 and overflow = 0.
- mode = 11, send 0x47 'G', 0x6D 'm', 0x40 '@' -> 0x67, 0x4D, 0x40. mode = 00, send 0x61 -> 0x61. Check that a mode change mid-frame takes effect on the byte whose stop bit follows it.
- Send 0x55 with the stop bit held low, then hold rx low for 30 cycles -> frame_err = 1, nothing pushed, fifo_count stays 0. After rx returns high, send 0x41 -> 0x41 is received and transmitted. clr_err -> frame_err = 0.
- tx_pause = 1, send 6 bytes 0x30..0x35 -> fifo_count reaches 4, overflow = 1, tx stays high. Release tx_pause -> 0x30..0x33 go out in order.
- Glitch: drive rx low for 3 cycles while idle -> no frame, no flag, tx idle.
- Assert rst_n low midway through a TX frame -> tx = 1 in the same cycle, fifo_count = 0. After release, the next received byte is transmitted correctly.
